// File: rtl/mmp_dac_pkg.sv
// Shared types and constants for the DAC frame scheduler / mixer.
// Optional soft-volume build: define MMP_DAC_MIX_SCHED_SOFT_VOL_EN.
package mmp_dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC0,
        ST_MAC1,
        ST_MAC2,
        ST_SAT,
        ST_COMMIT
    } state_t;

    localparam logic [4:0] PH_SNAP   = 5'd0;
    localparam logic [4:0] PH_COMMIT = 5'd5;
    localparam logic [4:0] PH_LOAD_R = 5'd15;
    localparam logic [4:0] PH_LOAD_L = 5'd31;

    localparam int N_SRC = 3;
    localparam int ACC_W = 22;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 22'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -22'sd32768;

endpackage

// File: rtl/mmp_dac_sat16.sv
// Arithmetic right shift of the mix accumulator followed by a clamp to signed 16 bits.
module mmp_dac_sat16
    import mmp_dac_pkg::*;
#(
    parameter int SHIFT = 3
) (
    input  logic signed [ACC_W-1:0] i_ACC,
    output logic signed [15:0]      o_SAT
);

    logic signed [ACC_W-1:0] w_shr;

    always_comb begin
        w_shr = i_ACC >>> SHIFT;
        if (w_shr > SAT_MAX) begin
            o_SAT = 16'sh7FFF;
        end else if (w_shr < SAT_MIN) begin
            o_SAT = 16'sh8000;
        end else begin
            o_SAT = w_shr[15:0];
        end
    end

endmodule

// File: rtl/mmp_dac_mix_sched.sv
// Frame scheduler and volume-weighted mixer for the DAC serializer; one shared MAC per frame.
// Build option: MMP_DAC_MIX_SCHED_SOFT_VOL_EN ramps per-source volume by 1 step per commit.
module mmp_dac_mix_sched
    import mmp_dac_pkg::*;
#(
    parameter int MIX_SHIFT = 0,
    parameter int VOL_W     = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_RST_n,
    input  logic signed [15:0]      i_SCC,
    input  logic signed [15:0]      i_PSG,
    input  logic signed [15:0]      i_OPLL,
    input  logic                    i_SCC_VALID,
    input  logic                    i_PSG_VALID,
    input  logic                    i_OPLL_VALID,
    input  logic        [VOL_W-1:0] i_VOL_SCC,
    input  logic        [VOL_W-1:0] i_VOL_PSG,
    input  logic        [VOL_W-1:0] i_VOL_OPLL,
    input  logic                    i_OVR_CLR,
    output logic signed [15:0]      o_SCC,
    output logic signed [15:0]      o_PSG,
    output logic signed [15:0]      o_OPLL,
    output logic signed [15:0]      o_ALL,
    output logic                    o_FRAME,
    output logic        [4:0]       o_PHASE,
    output logic        [2:0]       o_OVR
);

    state_t                  r_state;
    logic [4:0]              r_phase;
    logic signed [15:0]      r_pend [N_SRC];
    logic signed [15:0]      r_work [N_SRC];
    logic signed [15:0]      r_out  [N_SRC];
    logic [N_SRC-1:0]        r_fresh;
    logic [2:0]              r_ovr;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [15:0]      r_all;
    logic                    r_frame;

    logic signed [15:0]      w_in     [N_SRC];
    logic [VOL_W-1:0]        w_vol_in [N_SRC];
    logic [VOL_W-1:0]        w_vol    [N_SRC];
    logic [N_SRC-1:0]        w_valid;
    logic [N_SRC-1:0]        w_ovr_new;
    logic                    w_snap;
    logic [1:0]              w_mac_idx;
    logic signed [15:0]      w_mac_smp;
    logic [VOL_W-1:0]        w_mac_vol;
    logic signed [ACC_W-1:0] w_smp_ext;
    logic signed [ACC_W-1:0] w_vol_ext;
    logic signed [ACC_W-1:0] w_prod;
    logic signed [15:0]      w_sat;

    assign w_in[0]     = i_SCC;
    assign w_in[1]     = i_PSG;
    assign w_in[2]     = i_OPLL;
    assign w_vol_in[0] = i_VOL_SCC;
    assign w_vol_in[1] = i_VOL_PSG;
    assign w_vol_in[2] = i_VOL_OPLL;
    assign w_valid     = {i_OPLL_VALID, i_PSG_VALID, i_SCC_VALID};
    assign w_snap      = (r_phase == PH_SNAP);

    // A strobe in the snapshot cycle does not lose the old sample (it is being snapshotted).
    assign w_ovr_new = w_valid & r_fresh & {N_SRC{~w_snap}};

`ifdef MMP_DAC_MIX_SCHED_SOFT_VOL_EN
    logic [VOL_W-1:0] r_eff_vol [N_SRC];
    assign w_vol = r_eff_vol;
`else
    assign w_vol = w_vol_in;
`endif

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_mac_idx = 2'd0;
        case (r_state)
            ST_MAC1: w_mac_idx = 2'd1;
            ST_MAC2: w_mac_idx = 2'd2;
            default: w_mac_idx = 2'd0;
        endcase
    end

    assign w_mac_smp = r_work[w_mac_idx];
    assign w_mac_vol = w_vol[w_mac_idx];
    assign w_smp_ext = {{(ACC_W-16){w_mac_smp[15]}}, w_mac_smp};
    assign w_vol_ext = {{(ACC_W-VOL_W){1'b0}}, w_mac_vol};
    assign w_prod    = w_smp_ext * w_vol_ext;

    mmp_dac_sat16 #(
        .SHIFT(VOL_W - 1 + MIX_SHIFT)
    ) u_sat (
        .i_ACC(r_acc),
        .o_SAT(w_sat)
    );

    // NOTE: state uses non-blocking assignments only; reset is synchronous and clears every register.
    always_ff @(posedge i_CLK) begin
        if (!i_RST_n) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_fresh <= '0;
            r_ovr   <= '0;
            r_acc   <= '0;
            r_all   <= '0;
            r_frame <= 1'b0;
            for (int k = 0; k < N_SRC; k++) begin
                r_pend[k] <= '0;
                r_work[k] <= '0;
                r_out[k]  <= '0;
`ifdef MMP_DAC_MIX_SCHED_SOFT_VOL_EN
                r_eff_vol[k] <= '0;
`endif
            end
        end else begin
            r_phase <= r_phase + 5'd1;
            r_frame <= 1'b0;
            r_ovr   <= (i_OVR_CLR ? 3'b000 : r_ovr) | w_ovr_new;
            r_fresh <= w_snap ? w_valid : (r_fresh | w_valid);
            for (int k = 0; k < N_SRC; k++) begin
                if (w_valid[k]) r_pend[k] <= w_in[k];
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_snap) begin
                        for (int k = 0; k < N_SRC; k++) r_work[k] <= r_pend[k];
                        r_acc   <= '0;
                        r_state <= ST_MAC0;
                    end
                end
                ST_MAC0: begin
                    r_acc   <= r_acc + w_prod;
                    r_state <= ST_MAC1;
                end
                ST_MAC1: begin
                    r_acc   <= r_acc + w_prod;
                    r_state <= ST_MAC2;
                end
                ST_MAC2: begin
                    r_acc   <= r_acc + w_prod;
                    r_state <= ST_SAT;
                end
                ST_SAT: begin
                    // Written here so the new words are visible throughout the commit phase.
                    for (int k = 0; k < N_SRC; k++) r_out[k] <= r_work[k];
                    r_all   <= w_sat;
                    r_frame <= 1'b1;
                    r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
`ifdef MMP_DAC_MIX_SCHED_SOFT_VOL_EN
                    for (int k = 0; k < N_SRC; k++) begin
                        if (r_eff_vol[k] < w_vol_in[k])      r_eff_vol[k] <= r_eff_vol[k] + 1'b1;
                        else if (r_eff_vol[k] > w_vol_in[k]) r_eff_vol[k] <= r_eff_vol[k] - 1'b1;
                    end
`endif
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_SCC   = r_out[0];
    assign o_PSG   = r_out[1];
    assign o_OPLL  = r_out[2];
    assign o_ALL   = r_all;
    assign o_FRAME = r_frame;
    assign o_PHASE = r_phase;
    assign o_OVR   = r_ovr;

endmodule
